seven_seg_scan: RTL and testbench

Time-multiplexed driver for an N-digit common-anode seven-segment display. It double-buffers a packed BCD word and scans the digits one at a time at a programmable refresh rate. A guard interval with all digits off separates successive digits to prevent ghosting. It sits between the traffic-light controller's countdown logic and the board display pins, replacing per-digit static decoding.

---
 rtl/seg_pkg.sv | 54 +++++
 rtl/seg_scan_timer.sv | 43 ++++
 rtl/seven_seg_scan.sv | 150 +++++++++++++++
 tb/tb_seven_seg_scan.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the seven-segment scan driver.
//   - seg_bit_e : position of each segment inside a 7-bit pattern {g,f,e,d,c,b,a}
//   - SEG_W     : width of a segment pattern
//   - SEG_DIGIT : active-low patterns for BCD digits 0..9
//   - SEG_BLANK : all segments off (active-low)
//   - bcd_to_seg: nibble -> active-low pattern; 10..15 map to blank
package seg_pkg;

  typedef enum logic [2:0] {
    SEG_A = 3'd0,
    SEG_B = 3'd1,
    SEG_C = 3'd2,
    SEG_D = 3'd3,
    SEG_E = 3'd4,
    SEG_F = 3'd5,
    SEG_G = 3'd6
  } seg_bit_e;

  localparam int SEG_W = int'(SEG_G) + 1;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [3:0] nibble);
    logic [SEG_W-1:0] seg;
    case (nibble)
      4'd0:    seg = SEG_DIGIT[0];
      4'd1:    seg = SEG_DIGIT[1];
      4'd2:    seg = SEG_DIGIT[2];
      4'd3:    seg = SEG_DIGIT[3];
      4'd4:    seg = SEG_DIGIT[4];
      4'd5:    seg = SEG_DIGIT[5];
      4'd6:    seg = SEG_DIGIT[6];
      4'd7:    seg = SEG_DIGIT[7];
      4'd8:    seg = SEG_DIGIT[8];
      4'd9:    seg = SEG_DIGIT[9];
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// seg_scan_timer: slot counter and digit index for the scan driver.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   cnt        : cycle position inside the current digit slot
//   idx        : digit currently being scanned (0 = rightmost)
//   guard      : high while cnt is inside the all-digits-off guard interval
//   boundary   : high in the last cycle of the last digit slot of a frame
module seg_scan_timer #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 16,
  parameter int CNT_W        = $clog2(REFRESH_DIV),
  parameter int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] cnt,
  output logic [IDX_W-1:0] idx,
  output logic             guard,
  output logic             boundary
);

  logic cnt_last;
  logic idx_last;

  assign cnt_last = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign idx_last = (idx == IDX_W'(NUM_DIGITS - 1));
  assign guard    = (cnt < CNT_W'(GUARD_CYCLES));
  assign boundary = cnt_last && idx_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt_last) begin
      cnt <= '0;
      idx <= idx_last ? '0 : idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed driver for an N-digit common-anode
// seven-segment display with a double-buffered BCD word.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   value       : packed BCD, digit i = value[4i+3:4i], digit 0 rightmost
//   dp_in       : decimal-point request per digit, captured with value
//   load        : capture strobe for value/dp_in
//   segments    : {g,f,e,d,c,b,a}, active-low
//   dp          : decimal point, active-low
//   digit_en    : anode enables, active-low, at most one low
//   frame_done  : one-cycle pulse after the last digit slot of a frame
// Optional feature: define SEVEN_SEG_SCAN_LZB_EN for leading-zero blanking
// (digits above the most significant non-zero nibble are blanked; digit 0
// is always shown).
//
// Handshake: load is a strobe without back-pressure. Every cycle with
// load=1 is accepted; the newest word replaces any older pending one and
// becomes visible at the next frame boundary (immediately at the boundary
// if the strobe lands in the boundary cycle itself).
module seven_seg_scan
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic [SEG_W-1:0]        segments,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic                    guard;
  logic                    boundary;

  logic [4*NUM_DIGITS-1:0] shadow_val;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic                    pending;
  logic [4*NUM_DIGITS-1:0] active_val;
  logic [NUM_DIGITS-1:0]   active_dp;

  logic [NUM_DIGITS-1:0]   lead_zero;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_lz;
  logic [SEG_W-1:0]        seg_next;
  logic                    dp_next;
  logic [NUM_DIGITS-1:0]   en_next;

  seg_scan_timer #(
    .NUM_DIGITS   (NUM_DIGITS),
    .REFRESH_DIV  (REFRESH_DIV),
    .GUARD_CYCLES (GUARD_CYCLES),
    .CNT_W        (CNT_W),
    .IDX_W        (IDX_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .cnt      (cnt),
    .idx      (idx),
    .guard    (guard),
    .boundary (boundary)
  );

`ifdef SEVEN_SEG_SCAN_LZB_EN
  // lead_zero[i] is set when nibbles i..NUM_DIGITS-1 are all zero; bit 0
  // stays clear so a zero word still shows a single "0".
  always_comb begin
    logic zeros_above;
    zeros_above = 1'b1;
    lead_zero   = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zeros_above  = zeros_above && (active_val[4*i +: 4] == 4'd0);
      lead_zero[i] = zeros_above;
    end
  end
`else
  assign lead_zero = '0;
`endif

  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    en_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib = active_val[4*i +: 4];
        cur_dp  = active_dp[i];
        cur_lz  = lead_zero[i];
        if (!guard) en_next[i] = 1'b0;
      end
    end
    if (guard) begin
      seg_next = SEG_BLANK;
      dp_next  = 1'b1;
    end else begin
      seg_next = cur_lz ? SEG_BLANK : bcd_to_seg(cur_nib);
      dp_next  = ~cur_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
      active_val <= '0;
      active_dp  <= '0;
      segments   <= SEG_BLANK;
      dp         <= 1'b1;
      digit_en   <= '1;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
      end
      if (boundary) begin
        // A strobe in the boundary cycle goes straight to the display
        // instead of waiting a whole frame in the shadow register.
        pending <= 1'b0;
        if (load) begin
          active_val <= value;
          active_dp  <= dp_in;
        end else if (pending) begin
          active_val <= shadow_val;
          active_dp  <= shadow_dp;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
      segments   <= seg_next;
      dp         <= dp_next;
      digit_en   <= en_next;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: self-checking bench for seven_seg_scan with
// NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2 (32-cycle frames).
// Expected digit slots {digit_en, dp, segments} are queued per frame and
// compared by a monitor at the first lit cycle of each slot.
module tb_seven_seg_scan;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int GC = 2;
  localparam int W  = 12;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic [6:0]  segments;
  logic        dp;
  logic [3:0]  digit_en;
  logic        frame_done;

  always #5 clk = ~clk;

  seven_seg_scan #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .GUARD_CYCLES (GC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .dp_in      (dp_in),
    .load       (load),
    .segments   (segments),
    .dp         (dp),
    .digit_en   (digit_en),
    .frame_done (frame_done)
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  string cur_test = "none";

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] exp_slot(input logic [15:0] w, input logic [3:0] d, input int i);
    logic [3:0] nib;
    logic [6:0] s;
    logic [3:0] en;
    nib = w[i*4 +: 4];
    case (nib)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = 7'h7F;
    endcase
`ifdef SEVEN_SEG_SCAN_LZB_EN
    if (i >= 1 && (w >> (4*i)) == 16'd0) s = 7'h7F;
`endif
    en = 4'hF;
    en[i] = 1'b0;
    return {en, ~d[i], s};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_frame(input logic [15:0] w, input logic [3:0] d);
    for (int i = 0; i < ND; i++) exp_q.push_back(exp_slot(w, d, i));
  endtask

  task automatic drive_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  // Returns at the negedge where frame_done is high (first cycle of a frame).
  task automatic wait_frame();
    int n;
    n = 0;
    @(negedge clk);
    while (frame_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL %s frame_done_timeout: got %b want 1", cur_test, frame_done);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 120) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain: got %0d slots left want 0", cur_test, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  int off_run = 0;
  bit seen_lit = 1'b0;
  bit prev_off = 1'b1;

  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] got;
    if (!rst_n) begin
      off_run  = 0;
      seen_lit = 1'b0;
      prev_off = 1'b1;
    end else begin
      if (digit_en == 4'hF) begin
        off_run++;
        if (exp_q.size() != 0) begin
          checks++;
          if (segments !== 7'h7F || dp !== 1'b1) begin
            errors++;
            $display("FAIL %s guard_off: got seg=%b dp=%b want seg=1111111 dp=1", cur_test, segments, dp);
          end
        end
      end else begin
        if (exp_q.size() != 0) begin
          checks++;
          if ($countones(~digit_en) != 1) begin
            errors++;
            $display("FAIL %s one_enable: got digit_en=%b want exactly one low", cur_test, digit_en);
          end
        end
        if (prev_off && exp_q.size() != 0) begin
          got = {digit_en, dp, segments};
          e = exp_q.pop_front();
          checks++;
          if (got !== e) begin
            errors++;
            $display("FAIL %s slot: got en=%b dp=%b seg=%b want en=%b dp=%b seg=%b",
                     cur_test, got[11:8], got[7], got[6:0], e[11:8], e[7], e[6:0]);
          end
          if (seen_lit) begin
            checks++;
            if (off_run !== GC) begin
              errors++;
              $display("FAIL %s guard_len: got %0d want %0d", cur_test, off_run, GC);
            end
          end
        end
        off_run  = 0;
        seen_lit = 1'b1;
      end
      prev_off = (digit_en == 4'hF);
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [3:0] exp_en;
    cur_test = "reset";
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (segments !== 7'h7F) begin errors++; $display("FAIL reset segments: got %h want 7f", segments); end
    checks++;
    if (dp !== 1'b1) begin errors++; $display("FAIL reset dp: got %b want 1", dp); end
    checks++;
    if (digit_en !== 4'hF) begin errors++; $display("FAIL reset digit_en: got %b want 1111", digit_en); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset frame_done: got %b want 0", frame_done); end
    rst_n = 1'b1;
    for (int m = 1; m <= 9; m++) begin
      @(negedge clk);
      exp_en = (m >= 3 && m <= 8) ? 4'b1110 : 4'b1111;
      checks++;
      if (digit_en !== exp_en) begin
        errors++;
        $display("FAIL reset_scan cycle%0d: got %b want %b", m, digit_en, exp_en);
      end
      if (m == 3) begin
        checks++;
        if (segments !== 7'b1000000) begin
          errors++;
          $display("FAIL reset_zero_digit: got %b want 1000000", segments);
        end
      end
    end
  endtask

  task automatic test_load();
    int n;
    cur_test = "load";
    wait_frame();
    repeat (5) @(negedge clk);
    drive_load(16'h1234, 4'b0100);
    wait_frame();
    push_frame(16'h1234, 4'b0100);
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL load frame_done_width: got %b want 0", frame_done); end
    n = 1;
    while (frame_done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 32) begin errors++; $display("FAIL load frame_period: got %0d want 32", n); end
    drain();
  endtask

  task automatic test_midframe();
    cur_test = "midframe";
    wait_frame();
    push_frame(16'h1234, 4'b0100);
    repeat (12) @(negedge clk);
    drive_load(16'h9999, 4'b0001);
    wait_frame();
    push_frame(16'h9999, 4'b0001);
    repeat (3) @(negedge clk);
    drive_load(16'h5678, 4'b1000);
    repeat (20) @(negedge clk);
    drive_load(16'h4321, 4'b0110);
    wait_frame();
    push_frame(16'h4321, 4'b0110);
    drain();
  endtask

  task automatic test_boundary_load();
    cur_test = "boundary_load";
    wait_frame();
    repeat (RD*ND - 1) @(negedge clk);
    drive_load(16'h0007, 4'b0000);
    checks++;
    if (frame_done !== 1'b1) begin errors++; $display("FAIL boundary_load align: got %b want 1", frame_done); end
    push_frame(16'h0007, 4'b0000);
    drain();
  endtask

  task automatic test_blank();
    cur_test = "blank";
    wait_frame();
    repeat (2) @(negedge clk);
    drive_load(16'h00A5, 4'b0010);
    wait_frame();
    push_frame(16'h00A5, 4'b0010);
    drain();
  endtask

  task automatic test_reset_midframe();
    cur_test = "reset_midframe";
    wait_frame();
    repeat (2) @(negedge clk);
    drive_load(16'h3333, 4'b1111);
    repeat (16) @(negedge clk);
    checks++;
    if (digit_en !== 4'b1011) begin errors++; $display("FAIL reset_midframe in_digit2: got %b want 1011", digit_en); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (segments !== 7'h7F) begin errors++; $display("FAIL reset_midframe segments: got %h want 7f", segments); end
    checks++;
    if (dp !== 1'b1) begin errors++; $display("FAIL reset_midframe dp: got %b want 1", dp); end
    checks++;
    if (digit_en !== 4'hF) begin errors++; $display("FAIL reset_midframe digit_en: got %b want 1111", digit_en); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_midframe frame_done: got %b want 0", frame_done); end
    @(negedge clk);
    rst_n = 1'b1;
    push_frame(16'h0000, 4'b0000);
    push_frame(16'h0000, 4'b0000);
    drain();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_load();
    test_midframe();
    test_boundary_load();
    test_blank();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
